cmd_encod_linear_rw: RTL and testbench

Parametrised successor to the single-mode linear command encoders: generates the encoded DDR3 command sequence for one sequential read *or* write of up to 2^NUM_XFER_BITS full bursts (8×16-bit beats each) within a single page, bank and row. Sits between the memory-channel scheduler, which issues `start`, and the sequencer command buffer, which is written through `enc_cmd`/`enc_wr`. Unlike its predecessors, it supports both directions with one block, advances the column address per burst, reports `busy`, and optionally uses auto-precharge.

---
 rtl/cmd_encod_linear_rw.sv | 250 +++++++++++++++++++++++++
 tb/tb_cmd_encod_linear_rw.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_encod_linear_rw.sv
// cmd_encod_linear_rw
// Builds the DDR3 command word stream for one sequential read or write of
// up to 2^NUM_XFER_BITS bursts. All bursts stay in one page, bank and row.
// The stream is: ACTIVATE, two gap slots, N column commands, two tail
// pauses, PRECHARGE plus a wait pause, and a final pause word flagged
// "done". The result is N+8 words.
//
// Optional feature macro: CMD_ENCOD_AUTOPRE_EN. When it is defined, the last
// column command carries auto-precharge (A10=1). The explicit PRECHARGE and
// its wait are then dropped, which gives N+6 words.
//
// Ports
//   clk, rst    clock, synchronous active-high reset
//   bank_in     bank, latched on an accepted start
//   row_in      row, latched on an accepted start
//   start_col   first burst column in units of 8, latched on an accepted start
//   num128_in   burst count; 0 selects 2^NUM_XFER_BITS
//   wr_mode     1 = write sequence, 0 = read sequence
//   start       one-cycle request, ignored while a sequence is in flight
//   enc_cmd     encoded command word
//   enc_wr      enc_cmd is valid and should be written to the buffer
//   enc_done    one-cycle pulse on the cycle after the final word
//   busy        sequence in progress
//
// Word layout, msb to lsb:
//   addr[14:0] bank[2:0] rcw[2:0] odt_en cke sel dq_en dqs_en dqs_toggle
//   dci buf_wr buf_rd nop 0
//
// state   | meaning
// IDLE    | waiting for start
// ACT     | ACTIVATE the latched row
// GAP     | two pause slots before the first column command
// XFER    | one READ/WRITE per burst; the column advances each cycle
// TAIL1   | first tail pause (write: drive the last burst's data)
// TAIL2   | second tail pause
// PRE     | PRECHARGE the bank (not in the auto-precharge build)
// PREWAIT | pause after PRECHARGE (not in the auto-precharge build)
// FIN     | pause word with the done bit set

module cmd_encod_linear_rw #(
  parameter int ADDRESS_NUMBER = 15,
  parameter int COLADDR_NUMBER = 10,
  parameter int NUM_XFER_BITS  = 6,
  parameter int CMD_PAUSE_BITS = 10,
  parameter int CMD_DONE_BIT   = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2:0]                bank_in,
  input  logic [ADDRESS_NUMBER-1:0] row_in,
  input  logic [COLADDR_NUMBER-4:0] start_col,
  input  logic [NUM_XFER_BITS-1:0]  num128_in,
  input  logic                      wr_mode,
  input  logic                      start,
  output logic [31:0]               enc_cmd,
  output logic                      enc_wr,
  output logic                      enc_done,
  output logic                      busy
);

  localparam int ADDR_FIELD = 15;

  localparam logic [2:0] RCW_NOP   = 3'b000;
  localparam logic [2:0] RCW_READ  = 3'b010;
  localparam logic [2:0] RCW_WRITE = 3'b011;
  localparam logic [2:0] RCW_ACT   = 3'b100;
  localparam logic [2:0] RCW_PRE   = 3'b101;

  typedef enum logic [3:0] {
    S_IDLE, S_ACT, S_GAP, S_XFER, S_TAIL1, S_TAIL2, S_PRE, S_PREWAIT, S_FIN
  } state_t;

  state_t state, next_state;

  logic [2:0]                bank_q;
  logic [ADDRESS_NUMBER-1:0] row_q;
  logic [COLADDR_NUMBER-4:0] col_q;
  logic                      wr_q;
  logic [NUM_XFER_BITS:0]    n_q;
  logic [NUM_XFER_BITS:0]    xfer_left;
  logic                      gap_q;

  // The word is built from the state and then passes through one staging
  // register before enc_cmd. This places the ACTIVATE word two edges after
  // start is sampled.
  logic [31:0] w1_cmd;
  logic        w1_wr;
  logic        w1_fin;
  logic        fin2;

  logic                   accept;
  logic                   first_xfer;
  logic                   last_xfer;
  logic [NUM_XFER_BITS:0] n_init;

  logic [ADDR_FIELD-1:0] addr;
  logic [2:0]            rcw;
  logic odt, sel, dq_en, dqs_en, dqs_tog, dci, buf_wr, buf_rd, nop;
  logic w_valid, w_fin;
  logic [31:0] word;

  assign accept     = start && !busy && (state == S_IDLE);
  // A zero count means the full 2^NUM_XFER_BITS bursts. The extra msb holds that value exactly.
  assign n_init     = {(num128_in == '0), num128_in};
  assign first_xfer = (xfer_left == n_q);
  assign last_xfer  = (xfer_left == (NUM_XFER_BITS+1)'(1));

  always_comb begin
    next_state = state;
    addr    = '0;
    rcw     = RCW_NOP;
    odt     = 1'b0;
    sel     = 1'b0;
    dq_en   = 1'b0;
    dqs_en  = 1'b0;
    dqs_tog = 1'b0;
    dci     = 1'b0;
    buf_wr  = 1'b0;
    buf_rd  = 1'b0;
    nop     = 1'b0;
    w_valid = 1'b1;
    w_fin   = 1'b0;
    case (state)
      S_IDLE: begin
        w_valid = 1'b0;
        if (accept) next_state = S_ACT;
      end
      S_ACT: begin
        addr[ADDRESS_NUMBER-1:0] = row_q;
        rcw = RCW_ACT;
        nop = 1'b1;
        next_state = S_GAP;
      end
      S_GAP: begin
        buf_rd = wr_q;
        if (gap_q) next_state = S_XFER;
      end
      S_XFER: begin
        addr[COLADDR_NUMBER-1:3] = col_q;
`ifdef CMD_ENCOD_AUTOPRE_EN
        addr[10] = last_xfer;
`endif
        nop = 1'b1;
        if (wr_q) begin
          rcw     = RCW_WRITE;
          odt     = 1'b1;
          buf_rd  = 1'b1;
          sel     = first_xfer;
          dq_en   = !first_xfer;
          dqs_en  = !first_xfer;
          dqs_tog = !first_xfer;
        end else begin
          rcw    = RCW_READ;
          dci    = 1'b1;
          buf_wr = 1'b1;
        end
        if (last_xfer) next_state = S_TAIL1;
      end
      S_TAIL1: begin
        addr[CMD_PAUSE_BITS-1:0] = CMD_PAUSE_BITS'(2);
        if (wr_q) begin
          odt     = 1'b1;
          dq_en   = 1'b1;
          dqs_en  = 1'b1;
          dqs_tog = 1'b1;
        end else begin
          dci    = 1'b1;
          buf_wr = 1'b1;
        end
        next_state = S_TAIL2;
      end
      S_TAIL2: begin
        addr[CMD_PAUSE_BITS-1:0] = CMD_PAUSE_BITS'(2);
        dci = !wr_q;
`ifdef CMD_ENCOD_AUTOPRE_EN
        next_state = S_FIN;
`else
        next_state = S_PRE;
`endif
      end
      S_PRE: begin
        rcw = RCW_PRE;
        next_state = S_PREWAIT;
      end
      S_PREWAIT: begin
        addr[CMD_PAUSE_BITS-1:0] = CMD_PAUSE_BITS'(2);
        next_state = S_FIN;
      end
      S_FIN: begin
        addr[CMD_DONE_BIT] = 1'b1;
        w_fin = 1'b1;
        next_state = S_IDLE;
      end
      default: begin
        w_valid = 1'b0;
        next_state = S_IDLE;
      end
    endcase
  end

  assign word = {addr, bank_q, rcw, odt, 1'b0, sel, dq_en, dqs_en, dqs_tog,
                 dci, buf_wr, buf_rd, nop, 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bank_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      wr_q      <= 1'b0;
      n_q       <= '0;
      xfer_left <= '0;
      gap_q     <= 1'b0;
      w1_cmd    <= '0;
      w1_wr     <= 1'b0;
      w1_fin    <= 1'b0;
      fin2      <= 1'b0;
      enc_cmd   <= '0;
      enc_wr    <= 1'b0;
      enc_done  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        bank_q    <= bank_in;
        row_q     <= row_in;
        col_q     <= start_col;
        wr_q      <= wr_mode;
        n_q       <= n_init;
        xfer_left <= n_init;
      end
      if (state == S_GAP) gap_q <= !gap_q;
      if (state == S_XFER) begin
        col_q     <= col_q + 1'b1;
        xfer_left <= xfer_left - 1'b1;
      end
      w1_cmd   <= w_valid ? word : '0;
      w1_wr    <= w_valid;
      w1_fin   <= w_fin;
      enc_cmd  <= w1_cmd;
      enc_wr   <= w1_wr;
      fin2     <= w1_fin;
      enc_done <= fin2;
      // busy stays high until the final word has left the staging register.
      // It falls on the same edge that raises enc_done.
      busy     <= (state != S_IDLE) || w1_wr;
    end
  end

endmodule

// File: tb/tb_cmd_encod_linear_rw.sv
module tb_cmd_encod_linear_rw;

`ifdef CMD_ENCOD_AUTOPRE_EN
  localparam int  EXTRA   = 6;
  localparam bit  AUTOPRE = 1'b1;
`else
  localparam int  EXTRA   = 8;
  localparam bit  AUTOPRE = 1'b0;
`endif

  localparam logic [9:0] F_ODT = 10'b1000000000;
  localparam logic [9:0] F_SEL = 10'b0010000000;
  localparam logic [9:0] F_DQ  = 10'b0001000000;
  localparam logic [9:0] F_DQS = 10'b0000100000;
  localparam logic [9:0] F_TOG = 10'b0000010000;
  localparam logic [9:0] F_DCI = 10'b0000001000;
  localparam logic [9:0] F_BWR = 10'b0000000100;
  localparam logic [9:0] F_BRD = 10'b0000000010;
  localparam logic [9:0] F_NOP = 10'b0000000001;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  bank_in;
  logic [14:0] row_in;
  logic [6:0]  start_col;
  logic [5:0]  num128_in;
  logic        wr_mode;
  logic        start;
  logic [31:0] enc_cmd;
  logic        enc_wr;
  logic        enc_done;
  logic        busy;

  cmd_encod_linear_rw dut (
    .clk(clk), .rst(rst), .bank_in(bank_in), .row_in(row_in),
    .start_col(start_col), .num128_in(num128_in), .wr_mode(wr_mode),
    .start(start), .enc_cmd(enc_cmd), .enc_wr(enc_wr),
    .enc_done(enc_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] words[$];
  int          wcyc[$];
  int          dcyc[$];

  always @(negedge clk) begin
    if (enc_wr) begin
      words.push_back(enc_cmd);
      wcyc.push_back(cyc);
    end
    if (enc_done) dcyc.push_back(cyc);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [14:0] a, input logic [2:0] b,
                                     input logic [2:0] r, input logic [9:0] f);
    return {a, b, r, f, 1'b0};
  endfunction

  task automatic clear_log();
    words.delete();
    wcyc.delete();
    dcyc.delete();
  endtask

  task automatic launch(input bit wr, input logic [2:0] b, input logic [14:0] r,
                        input logic [6:0] c, input logic [5:0] n, output int t);
    @(negedge clk);
    wr_mode = wr; bank_in = b; row_in = r; start_col = c; num128_in = n;
    start = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok, output logic busy_at_done);
    ok = 1'b0;
    busy_at_done = 1'bx;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (enc_done) begin
        ok = 1'b1;
        busy_at_done = busy;
        break;
      end
    end
    @(negedge clk);
  endtask

  typedef struct {
    string       name;
    logic [31:0] exp;
  } wvec_t;

  typedef struct {
    string       name;
    bit          wr;
    logic [2:0]  b;
    logic [14:0] r;
    logic [6:0]  c;
    logic [5:0]  n;
    int          nx;
    logic [9:0]  c0, c1, c2;
  } seq_t;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wvec_t       t1[$];
    seq_t        sv[$];
    int          t, e, len, bad, npre;
    bit          ok;
    logic        bd;
    logic [9:0]  colv[3];
    logic [14:0] a;
    logic [9:0]  f;

    rst = 1'b1; start = 1'b0; wr_mode = 1'b0; bank_in = '0; row_in = '0;
    start_col = '0; num128_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_enc_cmd",  enc_cmd, 32'h0);
    chk("reset_enc_wr",   {31'b0, enc_wr}, 32'h0);
    chk("reset_enc_done", {31'b0, enc_done}, 32'h0);
    chk("reset_busy",     {31'b0, busy}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Write: bank 3, row 0x1234, start_col 5, N=1
    t1.push_back('{"w1_act",   mk(15'h1234, 3'd3, 3'b100, F_NOP)});
    t1.push_back('{"w1_gap0",  mk(15'h0, 3'd3, 3'b000, F_BRD)});
    t1.push_back('{"w1_gap1",  mk(15'h0, 3'd3, 3'b000, F_BRD)});
    t1.push_back('{"w1_write", mk(AUTOPRE ? 15'h0428 : 15'h0028, 3'd3, 3'b011,
                                  F_ODT | F_SEL | F_BRD | F_NOP)});
    t1.push_back('{"w1_tail1", mk(15'h2, 3'd3, 3'b000, F_ODT | F_DQ | F_DQS | F_TOG)});
    t1.push_back('{"w1_tail2", mk(15'h2, 3'd3, 3'b000, 10'h0)});
`ifndef CMD_ENCOD_AUTOPRE_EN
    t1.push_back('{"w1_pre",   mk(15'h0, 3'd3, 3'b101, 10'h0)});
    t1.push_back('{"w1_prew",  mk(15'h2, 3'd3, 3'b000, 10'h0)});
`endif
    t1.push_back('{"w1_fin",   mk(15'h0400, 3'd3, 3'b000, 10'h0)});

    clear_log();
    launch(1'b1, 3'd3, 15'h1234, 7'd5, 6'd1, t);
    @(negedge clk);
    chk("w1_busy_T1", {31'b0, busy}, 32'h1);
    wait_done(100, ok, bd);
    chk("w1_done_seen", {31'b0, ok}, 32'h1);
    chk("w1_busy_at_done", {31'b0, bd}, 32'h0);
    chk("w1_len", words.size(), t1.size());
    if (words.size() == t1.size()) begin
      for (int i = 0; i < t1.size(); i++) chk(t1[i].name, words[i], t1[i].exp);
      chk("w1_first_cyc", wcyc[0], t + 2);
      chk("w1_contig", wcyc[wcyc.size()-1] - wcyc[0], t1.size() - 1);
    end
    if (dcyc.size() > 0) chk("w1_done_cyc", dcyc[0], t + 2 + t1.size());
    chk("w1_done_count", dcyc.size(), 1);

    sv.push_back('{"rd_wrap",  1'b0, 3'd1, 15'h0ABC, 7'd126, 6'd3, 3,  10'h3F0, 10'h3F8, 10'h000});
    sv.push_back('{"wr_n2",    1'b1, 3'd7, 15'h7FFF, 7'd0,   6'd2, 2,  10'h000, 10'h008, 10'h000});
    sv.push_back('{"rd_c127",  1'b0, 3'd0, 15'h0000, 7'd127, 6'd1, 1,  10'h3F8, 10'h000, 10'h000});
    sv.push_back('{"rd_full",  1'b0, 3'd2, 15'h0005, 7'd100, 6'd0, 64, 10'h320, 10'h328, 10'h330});
    sv.push_back('{"wr_n5",    1'b1, 3'd5, 15'h2468, 7'd64,  6'd5, 5,  10'h200, 10'h208, 10'h210});

    foreach (sv[k]) begin
      clear_log();
      launch(sv[k].wr, sv[k].b, sv[k].r, sv[k].c, sv[k].n, t);
      wait_done(300, ok, bd);
      len = sv[k].nx + EXTRA;
      chk({sv[k].name, "_done_seen"}, {31'b0, ok}, 32'h1);
      chk({sv[k].name, "_len"}, words.size(), len);
      chk({sv[k].name, "_done_count"}, dcyc.size(), 1);
      if (words.size() == len) begin
        chk({sv[k].name, "_act"}, words[0], mk(sv[k].r, sv[k].b, 3'b100, F_NOP));
        colv[0] = sv[k].c0; colv[1] = sv[k].c1; colv[2] = sv[k].c2;
        for (int i = 0; i < 3 && i < sv[k].nx; i++) begin
          a = {5'b0, colv[i]};
          if (AUTOPRE && i == sv[k].nx - 1) a[10] = 1'b1;
          if (sv[k].wr)
            f = F_ODT | F_BRD | F_NOP | ((i == 0) ? F_SEL : (F_DQ | F_DQS | F_TOG));
          else
            f = F_DCI | F_BWR | F_NOP;
          chk($sformatf("%s_xfer%0d", sv[k].name, i), words[3+i],
              mk(a, sv[k].b, sv[k].wr ? 3'b011 : 3'b010, f));
        end
        bad = 0;
        for (int i = 0; i < sv[k].nx; i++)
          if (words[3+i][26:20] != 7'((int'(sv[k].c) + i) % 128)) bad++;
        chk({sv[k].name, "_col_sweep_errs"}, bad, 0);
        bad = 0;
        npre = 0;
        foreach (words[i]) begin
          if (words[i][16:14] != sv[k].b) bad++;
          if (words[i][13:11] == 3'b101) npre++;
        end
        chk({sv[k].name, "_bank_errs"}, bad, 0);
        chk({sv[k].name, "_pre_count"}, npre, AUTOPRE ? 0 : 1);
        chk({sv[k].name, "_fin"}, words[len-1], mk(15'h0400, sv[k].b, 3'b000, 10'h0));
        if (dcyc.size() > 0) chk({sv[k].name, "_done_cyc"}, dcyc[0], t + 2 + len);
      end
    end

    // start held high and inputs changed while busy: the run must not change
    clear_log();
    @(negedge clk);
    wr_mode = 1'b1; bank_in = 3'd4; row_in = 15'h0111; start_col = 7'd10; num128_in = 6'd4;
    start = 1'b1;
    @(negedge clk);
    bank_in = 3'd6; row_in = 15'h0222; start_col = 7'd50; num128_in = 6'd9; wr_mode = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b0;
    wait_done(100, ok, bd);
    repeat (6) @(negedge clk);
    chk("hold_len", words.size(), 4 + EXTRA);
    chk("hold_done_count", dcyc.size(), 1);
    if (words.size() > 3) begin
      chk("hold_act", words[0], mk(15'h0111, 3'd4, 3'b100, F_NOP));
      chk("hold_xfer0", words[3], mk(15'h0050, 3'd4, 3'b011, F_ODT | F_SEL | F_BRD | F_NOP));
    end

    // Back-to-back: the second start is presented on the enc_done cycle
    clear_log();
    launch(1'b0, 3'd1, 15'h0010, 7'd0, 6'd1, t);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (enc_done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("b2b_first_done", {31'b0, ok}, 32'h1);
    wr_mode = 1'b1; bank_in = 3'd2; row_in = 15'h0020; start_col = 7'd8; num128_in = 6'd1;
    start = 1'b1;
    e = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    wait_done(100, ok, bd);
    chk("b2b_second_done", {31'b0, ok}, 32'h1);
    chk("b2b_len", words.size(), 2 * (1 + EXTRA));
    chk("b2b_done_count", dcyc.size(), 2);
    if (words.size() == 2 * (1 + EXTRA)) begin
      chk("b2b_act2", words[1+EXTRA], mk(15'h0020, 3'd2, 3'b100, F_NOP));
      chk("b2b_act2_cyc", wcyc[1+EXTRA], e + 2);
    end

    // Reset during XFER: outputs clear on the next edge and no done follows
    clear_log();
    launch(1'b1, 3'd3, 15'h0055, 7'd0, 6'd8, t);
    repeat (6) @(negedge clk);
    chk("rst_mid_wr_before", {31'b0, enc_wr}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_enc_wr",   {31'b0, enc_wr}, 32'h0);
    chk("rst_mid_busy",     {31'b0, busy}, 32'h0);
    chk("rst_mid_enc_cmd",  enc_cmd, 32'h0);
    chk("rst_mid_enc_done", {31'b0, enc_done}, 32'h0);
    rst = 1'b0;
    clear_log();
    repeat (30) @(negedge clk);
    chk("rst_mid_no_words", words.size(), 0);
    chk("rst_mid_no_done", dcyc.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
